// File: rtl/sweep_acq_control.sv
// Steps a 10-bit DAC across a sweep. Each point reloads slow control, settles, then collects a header
// and MaxPackageNumber hit words. Define SWEEP_ACQ_TIMEOUT_EN to add a per-point ACQ time limit.
module sweep_acq_control #(
    parameter int SETTLE_CYCLES  = 16,
    parameter int RESET_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic        Clk,
    input  logic        reset_n,
    input  logic        SweepAcqStartStop,
    input  logic [9:0]  StartDac,
    input  logic [9:0]  EndDac,
    input  logic [9:0]  DacStep,
    input  logic [15:0] MaxPackageNumber,
    input  logic        SCParameterLoadDone,
    input  logic [15:0] ParallelData,
    input  logic        ParallelData_en,
    output logic [9:0]  SweepAcq10BitDac,
    output logic        SweepAcqMicrorocSCParameterLoad,
    output logic        SweepAcqMicrorocAcqStartStop,
    output logic        SweepAcqForceMicrorocAcqReset,
    output logic [15:0] SweepAcqData,
    output logic        SweepAcqData_en,
    output logic        SweepTestUsbStartStop,
    output logic        SweepAcqDone,
    output logic        SweepAcqTimeout,
    output logic [2:0]  state_dbg_o
);

    localparam int MAX_SR  = (SETTLE_CYCLES > RESET_CYCLES) ? SETTLE_CYCLES : RESET_CYCLES;
    localparam int MAX_CNT = (TIMEOUT_CYCLES > MAX_SR) ? TIMEOUT_CYCLES : MAX_SR;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    typedef enum logic [2:0] {IDLE, LOAD, WAIT_LOAD, SETTLE, ACQ, STOP, NEXT, DONE} state_t;

    state_t             state_q, state_d;
    logic               start_q;
    logic [9:0]         end_q, end_d;
    logic [9:0]         step_q, step_d;
    logic [15:0]        max_q, max_d;
    logic [9:0]         dac_q, dac_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [15:0]        pkt_q, pkt_d;
    logic [15:0]        data_q, data_d;
    logic               data_en_q, data_en_d;
    logic               usb_q, usb_d;
    logic               abort_q, abort_d;
    logic               timeout_q, timeout_d;

    always_comb begin
        state_d   = state_q;
        end_d     = end_q;
        step_d    = step_q;
        max_d     = max_q;
        dac_d     = dac_q;
        cnt_d     = cnt_q;
        pkt_d     = pkt_q;
        data_d    = data_q;
        data_en_d = 1'b0;
        usb_d     = usb_q;
        abort_d   = abort_q;
        timeout_d = timeout_q;
        case (state_q)
            IDLE: begin
                if (SweepAcqStartStop && !start_q) begin
                    state_d   = LOAD;
                    end_d     = EndDac;
                    step_d    = (DacStep == 10'd0) ? 10'd1 : DacStep;
                    max_d     = (MaxPackageNumber == 16'd0) ? 16'd1 : MaxPackageNumber;
                    dac_d     = StartDac;
                    usb_d     = 1'b1;
                    abort_d   = 1'b0;
                    timeout_d = 1'b0;
                end
            end
            LOAD: state_d = WAIT_LOAD;
            WAIT_LOAD: begin
                if (SCParameterLoadDone) begin
                    state_d = SETTLE;
                    cnt_d   = '0;
                end
            end
            SETTLE: begin
                // Header goes out on the entry edge, so no hit word can ever collide with it.
                if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
                    state_d   = ACQ;
                    cnt_d     = '0;
                    pkt_d     = 16'd0;
                    data_d    = {6'b111100, dac_q};
                    data_en_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ACQ: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (ParallelData_en) begin
                    data_d    = ParallelData;
                    data_en_d = 1'b1;
                    pkt_d     = pkt_q + 16'd1;
                end
                if (ParallelData_en && (pkt_q + 16'd1 >= max_q)) begin
                    state_d = STOP;
                    cnt_d   = '0;
                end
`ifdef SWEEP_ACQ_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d   = STOP;
                    cnt_d     = '0;
                    timeout_d = 1'b1;
                end
`endif
            end
            STOP: begin
                if (cnt_q == CNT_W'(RESET_CYCLES - 1)) begin
                    if (abort_q || !SweepAcqStartStop) begin
                        state_d = IDLE;
                        usb_d   = 1'b0;
                    end else begin
                        state_d = NEXT;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            NEXT: begin
                // 11-bit sum so a step that would wrap past 1023 still ends the sweep.
                if ((dac_q >= end_q) || (({1'b0, dac_q} + {1'b0, step_q}) > {1'b0, end_q})) begin
                    state_d = DONE;
                    usb_d   = 1'b0;
                end else begin
                    dac_d   = dac_q + step_q;
                    state_d = LOAD;
                end
            end
            DONE: begin
                if (!SweepAcqStartStop) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Abort: a STOP already in progress keeps its pulse, everything else starts a fresh one.
        if (!SweepAcqStartStop) begin
            if (state_q inside {LOAD, WAIT_LOAD, SETTLE, ACQ, NEXT}) begin
                state_d = STOP;
                cnt_d   = '0;
                abort_d = 1'b1;
            end else if (state_q == STOP) begin
                abort_d = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            start_q   <= 1'b0;
            end_q     <= '0;
            step_q    <= '0;
            max_q     <= '0;
            dac_q     <= '0;
            cnt_q     <= '0;
            pkt_q     <= '0;
            data_q    <= '0;
            data_en_q <= 1'b0;
            usb_q     <= 1'b0;
            abort_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            start_q   <= SweepAcqStartStop;
            end_q     <= end_d;
            step_q    <= step_d;
            max_q     <= max_d;
            dac_q     <= dac_d;
            cnt_q     <= cnt_d;
            pkt_q     <= pkt_d;
            data_q    <= data_d;
            data_en_q <= data_en_d;
            usb_q     <= usb_d;
            abort_q   <= abort_d;
            timeout_q <= timeout_d;
        end
    end

    assign SweepAcq10BitDac                = dac_q;
    assign SweepAcqMicrorocSCParameterLoad = (state_q == LOAD);
    assign SweepAcqMicrorocAcqStartStop    = (state_q == ACQ);
    assign SweepAcqForceMicrorocAcqReset   = (state_q == STOP);
    assign SweepAcqData                    = data_q;
    assign SweepAcqData_en                 = data_en_q;
    assign SweepTestUsbStartStop           = usb_q;
    assign SweepAcqDone                    = (state_q == DONE);
    assign SweepAcqTimeout                 = timeout_q;
    assign state_dbg_o                     = state_q;

endmodule

// File: tb/tb_sweep_acq_control.sv
// Bench for sweep_acq_control: random and directed sweeps scored against a DAC point-list model,
// plus abort, reset-during-settle and, with SWEEP_ACQ_TIMEOUT_EN, per-point timeout.
module tb_sweep_acq_control;

    localparam int SETTLE = 5;
    localparam int RST_W  = 4;
    localparam int TMO    = 100;

    logic        Clk = 1'b0;
    logic        reset_n;
    logic        SweepAcqStartStop;
    logic [9:0]  StartDac, EndDac, DacStep;
    logic [15:0] MaxPackageNumber;
    logic        SCParameterLoadDone;
    logic [15:0] ParallelData;
    logic        ParallelData_en;
    logic [9:0]  SweepAcq10BitDac;
    logic        SweepAcqMicrorocSCParameterLoad;
    logic        SweepAcqMicrorocAcqStartStop;
    logic        SweepAcqForceMicrorocAcqReset;
    logic [15:0] SweepAcqData;
    logic        SweepAcqData_en;
    logic        SweepTestUsbStartStop;
    logic        SweepAcqDone;
    logic        SweepAcqTimeout;
    logic [2:0]  dut_state;

    int          tests_run = 0;
    int          tests_failed = 0;
    logic [15:0] exp_q[$];
    logic [15:0] rx_q[$];
    int          frc_w_q[$];
    int          pts_q[$];
    int          frc_run = 0;
    int          load_cnt = 0;
    bit          done_seen = 1'b0;

    sweep_acq_control #(
        .SETTLE_CYCLES (SETTLE),
        .RESET_CYCLES  (RST_W),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .Clk                            (Clk),
        .reset_n                        (reset_n),
        .SweepAcqStartStop              (SweepAcqStartStop),
        .StartDac                       (StartDac),
        .EndDac                         (EndDac),
        .DacStep                        (DacStep),
        .MaxPackageNumber               (MaxPackageNumber),
        .SCParameterLoadDone            (SCParameterLoadDone),
        .ParallelData                   (ParallelData),
        .ParallelData_en                (ParallelData_en),
        .SweepAcq10BitDac               (SweepAcq10BitDac),
        .SweepAcqMicrorocSCParameterLoad(SweepAcqMicrorocSCParameterLoad),
        .SweepAcqMicrorocAcqStartStop   (SweepAcqMicrorocAcqStartStop),
        .SweepAcqForceMicrorocAcqReset  (SweepAcqForceMicrorocAcqReset),
        .SweepAcqData                   (SweepAcqData),
        .SweepAcqData_en                (SweepAcqData_en),
        .SweepTestUsbStartStop          (SweepTestUsbStartStop),
        .SweepAcqDone                   (SweepAcqDone),
        .SweepAcqTimeout                (SweepAcqTimeout),
        .state_dbg_o                    (dut_state)
    );

    // Clock and watchdog
    always #5 Clk = ~Clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Output monitor, sampled mid-cycle
    always @(negedge Clk) begin
        if (SweepAcqData_en) rx_q.push_back(SweepAcqData);
        if (SweepAcqMicrorocSCParameterLoad) load_cnt++;
        if (SweepAcqDone) done_seen = 1'b1;
        if (SweepAcqForceMicrorocAcqReset) begin
            frc_run++;
        end else if (frc_run != 0) begin
            frc_w_q.push_back(frc_run);
            frc_run = 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
            $error("%s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit cond(input int which);
        case (which)
            0:       return SweepAcqMicrorocSCParameterLoad === 1'b1;
            1:       return SweepAcqMicrorocAcqStartStop === 1'b1;
            2:       return SweepAcqMicrorocAcqStartStop === 1'b0;
            3:       return SweepAcqDone === 1'b1;
            default: return SweepAcqForceMicrorocAcqReset === 1'b0;
        endcase
    endfunction

    task automatic wait_cond(input int which, input int bound, output int cycles);
        cycles = 0;
        while (!cond(which) && cycles < bound) begin
            @(negedge Clk);
            cycles++;
        end
        if (!cond(which)) check($sformatf("wait_cond_%0d", which), 32'(cond(which)), 32'd1);
    endtask

    // Reference model: every StartDac + k*step not above EndDac, and always StartDac itself.
    task automatic build_points(input int s, input int e, input int st);
        int step;
        step = (st == 0) ? 1 : st;
        pts_q.delete();
        pts_q.push_back(s);
        for (int d = s + step; d <= e; d += step) pts_q.push_back(d);
    endtask

    task automatic start_run(input int s, input int e, input int st, input int mx);
        rx_q.delete();
        exp_q.delete();
        frc_w_q.delete();
        load_cnt  = 0;
        done_seen = 1'b0;
        StartDac          = 10'(s);
        EndDac            = 10'(e);
        DacStep           = 10'(st);
        MaxPackageNumber  = 16'(mx);
        SweepAcqStartStop = 1'b1;
        @(negedge Clk);
    endtask

    task automatic do_point(input int dac, input int nw, input bit abort_it);
        int          cyc;
        logic [15:0] w;
        wait_cond(0, 40, cyc);
        StartDac         = 10'($urandom_range(0, 1023));
        EndDac           = 10'($urandom_range(0, 1023));
        DacStep          = 10'($urandom_range(0, 1023));
        MaxPackageNumber = 16'($urandom_range(0, 65535));
        @(negedge Clk);
        repeat ($urandom_range(0, 3)) @(negedge Clk);
        SCParameterLoadDone = 1'b1;
        @(negedge Clk);
        SCParameterLoadDone = 1'b0;
        wait_cond(1, SETTLE + 10, cyc);
        check("settle_len", cyc, SETTLE);
        check("hdr_en", 32'(SweepAcqData_en), 32'd1);
        check("hdr_word", 32'(SweepAcqData), 32'({6'b111100, 10'(dac)}));
        check("dac_out", 32'(SweepAcq10BitDac), dac);
        check("usb_on", 32'(SweepTestUsbStartStop), 32'd1);
        exp_q.push_back({6'b111100, 10'(dac)});
        if (abort_it) begin
            SweepAcqStartStop = 1'b0;
            @(negedge Clk);
            check("abort_acq_off", 32'(SweepAcqMicrorocAcqStartStop), 32'd0);
            check("abort_force_on", 32'(SweepAcqForceMicrorocAcqReset), 32'd1);
            return;
        end
        for (int i = 0; i < nw; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge Clk);
            w = 16'($urandom_range(0, 65535));
            ParallelData    = w;
            ParallelData_en = 1'b1;
            exp_q.push_back(w);
            @(negedge Clk);
            ParallelData_en = 1'b0;
            check("fwd_en", 32'(SweepAcqData_en), 32'd1);
            check("fwd_word", 32'(SweepAcqData), 32'(w));
        end
        if (nw > 0) begin
            check("stop_force", 32'(SweepAcqForceMicrorocAcqReset), 32'd1);
            ParallelData    = ~w;
            ParallelData_en = 1'b1;
            @(negedge Clk);
            ParallelData_en = 1'b0;
            check("stop_discard", 32'(SweepAcqData_en), 32'd0);
        end
        wait_cond(2, TMO + 20, cyc);
        if (nw == 0) check("acq_timeout_len", cyc, TMO);
    endtask

    task automatic finish_run(input bit exp_tmo);
        int cyc;
        wait_cond(3, 40, cyc);
        check("done", 32'(SweepAcqDone), 32'd1);
        check("usb_off_done", 32'(SweepTestUsbStartStop), 32'd0);
        check("load_pulses", load_cnt, pts_q.size());
        check("frc_pulses", frc_w_q.size(), pts_q.size());
        foreach (frc_w_q[i]) check("frc_width", frc_w_q[i], RST_W);
        check("rx_count", rx_q.size(), exp_q.size());
        for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++)
            check("rx_word", 32'(rx_q[i]), 32'(exp_q[i]));
        check("timeout_flag", 32'(SweepAcqTimeout), 32'(exp_tmo));
        SweepAcqStartStop = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        check("done_clear", 32'(SweepAcqDone), 32'd0);
    endtask

    task automatic run_sweep(input int s, input int e, input int st, input int mx, input int nw,
                             input bit exp_tmo);
        build_points(s, e, st);
        start_run(s, e, st, mx);
        foreach (pts_q[i]) do_point(pts_q[i], nw, 1'b0);
        finish_run(exp_tmo);
    endtask

    initial begin
        int cyc, s, e, st, mx;
        reset_n             = 1'b0;
        SweepAcqStartStop   = 1'b0;
        StartDac            = '0;
        EndDac              = '0;
        DacStep             = '0;
        MaxPackageNumber    = '0;
        SCParameterLoadDone = 1'b0;
        ParallelData        = '0;
        ParallelData_en     = 1'b0;
        #1;
        check("reset_dac_data", 32'({SweepAcq10BitDac, SweepAcqData}), 32'd0);
        check("reset_ctl", 32'({SweepAcqMicrorocSCParameterLoad, SweepAcqMicrorocAcqStartStop,
              SweepAcqForceMicrorocAcqReset, SweepAcqData_en, SweepTestUsbStartStop,
              SweepAcqDone, SweepAcqTimeout}), 32'd0);
        repeat (3) @(negedge Clk);
        reset_n = 1'b1;
        @(negedge Clk);

        // Directed sweeps
        run_sweep(100, 102, 1, 3, 3, 1'b0);
        run_sweep(0, 10, 4, 2, 2, 1'b0);
        run_sweep(50, 20, 0, 1, 1, 1'b0);
        run_sweep(1020, 1023, 1000, 0, 1, 1'b0);
        run_sweep(1020, 1023, 3, 1, 1, 1'b0);

        // Random sweeps
        for (int k = 0; k < 5; k++) begin
            s  = $urandom_range(0, 1000);
            e  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 1023) : s + $urandom_range(0, 12);
            st = $urandom_range(0, 5);
            mx = $urandom_range(0, 3);
            run_sweep(s, e, st, mx, (mx == 0) ? 1 : mx, 1'b0);
        end

        // Abort during ACQ of the second point
        start_run(10, 20, 1, 2);
        do_point(10, 2, 1'b0);
        do_point(11, 0, 1'b1);
        wait_cond(4, 20, cyc);
        @(negedge Clk);
        repeat (5) @(negedge Clk);
        check("abort_frc_pulses", frc_w_q.size(), 2);
        if (frc_w_q.size() == 2) check("abort_frc_width", frc_w_q[1], RST_W);
        check("abort_no_done", 32'(done_seen), 32'd0);
        check("abort_loads", load_cnt, 2);
        check("abort_usb_off", 32'(SweepTestUsbStartStop), 32'd0);
        check("abort_rx_count", rx_q.size(), exp_q.size());
        for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++)
            check("abort_rx_word", 32'(rx_q[i]), 32'(exp_q[i]));

        // Reset asserted during SETTLE, then a full sweep
        start_run(200, 203, 1, 1);
        do_point(200, 1, 1'b0);
        wait_cond(0, 40, cyc);
        @(negedge Clk);
        SCParameterLoadDone = 1'b1;
        @(negedge Clk);
        SCParameterLoadDone = 1'b0;
        repeat (2) @(negedge Clk);
        reset_n = 1'b0;
        #1;
        check("rst_dac_data", 32'({SweepAcq10BitDac, SweepAcqData}), 32'd0);
        check("rst_ctl", 32'({SweepAcqMicrorocSCParameterLoad, SweepAcqMicrorocAcqStartStop,
              SweepAcqForceMicrorocAcqReset, SweepAcqData_en, SweepTestUsbStartStop,
              SweepAcqDone, SweepAcqTimeout}), 32'd0);
        SweepAcqStartStop = 1'b0;
        repeat (3) @(negedge Clk);
        reset_n = 1'b1;
        frc_run = 0;
        @(negedge Clk);
        run_sweep(200, 203, 1, 1, 1, 1'b0);

`ifdef SWEEP_ACQ_TIMEOUT_EN
        // No hit words: every point must time out and the sweep still completes
        run_sweep(5, 6, 1, 2, 0, 1'b1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/sweep_acq_control.md
SWEEP_ACQ_CONTROL -- requirements
Module: sweep_acq_control

Interface
REQ-001 The block SHALL have parameter SETTLE_CYCLES, default 16: idle cycles after SC load done, before acquisition starts.
REQ-002 The block SHALL have parameter RESET_CYCLES, default 4: width of the force-reset pulse after each DAC point.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 1000000: per-point acquisition limit, used only under SWEEP_ACQ_TIMEOUT_EN.
REQ-004 Clk  in  1  single clock, all logic on rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 SweepAcqStartStop  in  1  level; high = run sweep, low = idle/abort.
REQ-007 StartDac / EndDac / DacStep  in  10 each  sweep bounds and increment, sampled on run start.
REQ-008 MaxPackageNumber  in  16  hit words to collect per DAC point, sampled on run start.
REQ-009 SCParameterLoadDone  in  1  one-cycle pulse from slow-control loader.
REQ-010 ParallelData / ParallelData_en  in  16/1  ASIC acquisition word and strobe.
REQ-011 SweepAcq10BitDac  out  10  current DAC code.
REQ-012 SweepAcqMicrorocSCParameterLoad  out  1  one-cycle load request.
REQ-013 SweepAcqMicrorocAcqStartStop  out  1  ASIC acquisition enable.
REQ-014 SweepAcqForceMicrorocAcqReset  out  1  acquisition force reset.
REQ-015 SweepAcqData / SweepAcqData_en  out  16/1  USB FIFO word and strobe.
REQ-016 SweepTestUsbStartStop  out  1  USB transfer enable.
REQ-017 SweepAcqDone  out  1  sweep complete.
REQ-018 SweepAcqTimeout  out  1  sticky; set when any point timed out.

Function
REQ-019 The FSM SHALL use states IDLE, LOAD, WAIT_LOAD, SETTLE, ACQ, STOP, NEXT, DONE.
REQ-020 IDLE->LOAD on SweepAcqStartStop rising: latch configuration, DAC=StartDac, Timeout=0, SweepTestUsbStartStop=1.
REQ-021 LOAD SHALL pulse SweepAcqMicrorocSCParameterLoad for exactly one cycle, then go to WAIT_LOAD.
REQ-022 WAIT_LOAD->SETTLE on SCParameterLoadDone; SETTLE->ACQ after exactly SETTLE_CYCLES cycles.
REQ-023 On ACQ entry: emit one header word {6'b111100, DAC}; hold SweepAcqMicrorocAcqStartStop=1 throughout ACQ.
REQ-024 In ACQ, each ParallelData_en word SHALL be forwarded to SweepAcqData one cycle later and counted.
REQ-025 If a data word coincides with header emission, the header SHALL go first and the data word one cycle later; no word is lost.
REQ-026 ACQ->STOP when count reaches MaxPackageNumber; MaxPackageNumber=0 SHALL be treated as 1.
REQ-027 STOP: drop AcqStartStop, assert ForceReset for RESET_CYCLES cycles; words arriving in STOP are discarded.
REQ-028 NEXT: if DAC>=EndDac or DAC+DacStep (11-bit sum) >EndDac, go to DONE; else DAC+=DacStep, go to LOAD.
REQ-029 DacStep=0 SHALL be treated as 1; StartDac>EndDac SHALL yield exactly one point at StartDac.
REQ-030 DONE: SweepAcqDone=1 and SweepTestUsbStartStop=0 until SweepAcqStartStop goes low, then IDLE.
REQ-031 SweepAcqStartStop low in any non-IDLE, non-DONE state SHALL abort: AcqStartStop=0, one RESET_CYCLES ForceReset pulse, then IDLE, Done stays 0.
REQ-032 Configuration inputs changed mid-sweep SHALL have no effect until the next run.

Reset
REQ-033 On reset_n low, all outputs SHALL be 0, SweepAcq10BitDac=0, FSM=IDLE, counters=0, immediately and asynchronously.

Configuration
REQ-034 With SWEEP_ACQ_TIMEOUT_EN defined, ACQ SHALL exit to STOP after TIMEOUT_CYCLES cycles in ACQ and set SweepAcqTimeout.
REQ-035 Without SWEEP_ACQ_TIMEOUT_EN, ACQ waits indefinitely and SweepAcqTimeout SHALL be constant 0.

Verification
REQ-036 Start=100, End=102, Step=1, Max=3, 3 words per point -> headers 0xF064, 0xF065, 0xF066, each followed by 3 data words; 3 load pulses; Done=1.
REQ-037 Start=0, End=10, Step=4 -> points 0, 4, 8 only; Done after third STOP.
REQ-038 Start=50, End=20, Step=0 -> single point at 50 (header 0xF032), then Done.
REQ-039 Start deasserted during ACQ of second point -> AcqStartStop=0 next cycle, 4-cycle ForceReset, IDLE, Done never 1.
REQ-040 With macro, TIMEOUT_CYCLES=100, no data words -> STOP after 100 ACQ cycles, Timeout=1, sweep continues to Done.
REQ-041 reset_n low during SETTLE -> all outputs 0 immediately; restart performs a full sweep from StartDac.
